// File: rtl/ppudata_port.sv
// ---------------------------------------------------------------------------
// ppudata_port
//   CPU-side VRAM access port of the PPU. Provides the PPUADDR ($2006)
//   two-write address latch and PPUDATA ($2007) buffered read / write with
//   auto-increment. Nametable accesses are folded onto the 2KB VRAM through
//   the cartridge mirroring mode. Each access is carried out on VRAM port 2
//   on a cycle that has both the PPU clock enable and the arbiter grant.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   clk_en       PPU clock enable; VRAM commits only on cycles where it is high
//   reg_sel      CPU register index ($2000 + reg_sel)
//   reg_wr/rd    one-cycle CPU write / read strobes
//   cpu_wdata    CPU write data
//   inc32        address step select: 32 when high, else 1
//   mirror       0 horizontal, 1 vertical, 2 single-lo, 3 single-hi
//   vram_gnt     arbiter grant for VRAM port 2
//   vram_rdata   VRAM port 2 read data (combinational from vram_addr)
//   vram_addr    VRAM port 2 address (registered, latched with the access)
//   vram_we      VRAM port 2 write enable
//   vram_wdata   VRAM port 2 write data (registered)
//   vram_req     access pending, request to the arbiter
//   cpu_rdata    PPUDATA read buffer
//   ppu_addr     current v address
//   busy         an access is in flight
// ---------------------------------------------------------------------------
module ppudata_port #(
  parameter int VRAM_AW = 11,
  parameter int PPU_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [2:0]         reg_sel,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [7:0]         cpu_wdata,
  input  logic               inc32,
  input  logic [1:0]         mirror,
  input  logic               vram_gnt,
  input  logic [7:0]         vram_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  output logic               vram_req,
  output logic [7:0]         cpu_rdata,
  output logic [PPU_AW-1:0]  ppu_addr,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1,
    RD_PEND = 2'd2
  } state_t;

  localparam logic [PPU_AW-1:0] STEP_1  = PPU_AW'(1);
  localparam logic [PPU_AW-1:0] STEP_32 = PPU_AW'(32);

  state_t               state_r;
  logic [PPU_AW-1:0]    ppu_addr_r;
  logic [PPU_AW-1:0]    acc_addr_r;   // address of the access in flight
  logic                 w_r;          // $2006 write toggle
  logic [7:0]           rd_buf_r;
  logic [VRAM_AW-1:0]   vram_addr_r;
  logic [7:0]           vram_wdata_r;
  logic                 we_arm_r;     // write pending, waiting for a grant
  logic                 vram_req_r;
  logic                 busy_r;

  logic                 data_wr_s;
  logic                 data_rd_s;
  logic                 addr_wr_s;
  logic                 stat_rd_s;
  logic                 commit_s;

  // Nametable window: $2000-$2FFF and its $3000-$3EFF mirror; palette excluded.
  function automatic logic is_vram(input logic [PPU_AW-1:0] a);
    logic hit;
    hit = (a[13:12] == 2'b10) || ((a[13:12] == 2'b11) && (a[11:8] != 4'hF));
    return hit;
  endfunction

  // Fold the 4 logical nametables onto 2 physical ones.
  function automatic logic [VRAM_AW-1:0] map_vram(input logic [PPU_AW-1:0] a,
                                                  input logic [1:0]        m);
    logic mbit;
    case (m)
      2'd0:    mbit = a[11];
      2'd1:    mbit = a[10];
      2'd2:    mbit = 1'b0;
      2'd3:    mbit = 1'b1;
      default: mbit = 1'b0;
    endcase
    return {mbit, a[VRAM_AW-2:0]};
  endfunction

  // Auto-increment, wrapping naturally at the top of the 14-bit space.
  function automatic logic [PPU_AW-1:0] step_addr(input logic [PPU_AW-1:0] a,
                                                  input logic              big);
    logic [PPU_AW-1:0] nxt;
    if (big) begin
      nxt = a + STEP_32;
    end else begin
      nxt = a + STEP_1;
    end
    return nxt;
  endfunction

  assign data_wr_s = reg_wr && (reg_sel == 3'd7);
  assign data_rd_s = reg_rd && (reg_sel == 3'd7);
  assign addr_wr_s = reg_wr && (reg_sel == 3'd6);
  assign stat_rd_s = reg_rd && (reg_sel == 3'd2);
  assign commit_s  = clk_en && vram_gnt;

  // Address latch, access FSM and read buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ppu_addr_r   <= '0;
      acc_addr_r   <= '0;
      w_r          <= 1'b0;
      rd_buf_r     <= 8'h00;
      vram_addr_r  <= '0;
      vram_wdata_r <= 8'h00;
      we_arm_r     <= 1'b0;
      vram_req_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (stat_rd_s) begin
        w_r <= 1'b0;
      end

      // $2006 is honoured even while busy; a completing access below
      // overwrites ppu_addr with its own incremented address.
      if (addr_wr_s) begin
        if (!w_r) begin
          ppu_addr_r[PPU_AW-1:8] <= cpu_wdata[PPU_AW-9:0];
          w_r                    <= 1'b1;
        end else begin
          ppu_addr_r[7:0] <= cpu_wdata;
          w_r             <= 1'b0;
        end
      end

      case (state_r)
        IDLE: begin
          if (data_wr_s) begin
            acc_addr_r  <= ppu_addr_r;
            vram_addr_r <= map_vram(ppu_addr_r, mirror);
            if (is_vram(ppu_addr_r)) begin
              vram_wdata_r <= cpu_wdata;
              we_arm_r     <= 1'b1;
              vram_req_r   <= 1'b1;
              busy_r       <= 1'b1;
              state_r      <= WR_PEND;
            end else begin
              // CHR / palette writes are not handled by this port.
              ppu_addr_r <= step_addr(ppu_addr_r, inc32);
            end
          end else if (data_rd_s) begin
            acc_addr_r  <= ppu_addr_r;
            vram_addr_r <= map_vram(ppu_addr_r, mirror);
            if (is_vram(ppu_addr_r)) begin
              vram_req_r <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= RD_PEND;
            end else begin
              rd_buf_r   <= 8'h00;
              ppu_addr_r <= step_addr(ppu_addr_r, inc32);
            end
          end
        end

        WR_PEND: begin
          if (commit_s) begin
            ppu_addr_r <= step_addr(acc_addr_r, inc32);
            we_arm_r   <= 1'b0;
            vram_req_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end

        RD_PEND: begin
          if (commit_s) begin
            rd_buf_r   <= vram_rdata;
            ppu_addr_r <= step_addr(acc_addr_r, inc32);
            vram_req_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end

        default: begin
          we_arm_r   <= 1'b0;
          vram_req_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // The write enable is gated by the live grant so that a revoked grant
  // never leaves a write enable asserted on a port the renderer owns.
  assign vram_we    = we_arm_r && vram_gnt;
  assign vram_addr  = vram_addr_r;
  assign vram_wdata = vram_wdata_r;
  assign vram_req   = vram_req_r;
  assign cpu_rdata  = rd_buf_r;
  assign ppu_addr   = ppu_addr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ppudata_port.sv
// ---------------------------------------------------------------------------
// tb_ppudata_port
//   Directed bench for ppudata_port with a 2KB VRAM model on port 2 and a
//   divide-by-4 clock enable.
// ---------------------------------------------------------------------------
module tb_ppudata_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [2:0]  reg_sel = 3'd0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        inc32 = 1'b0;
  logic [1:0]  mirror = 2'd0;
  logic        vram_gnt = 1'b1;
  logic [7:0]  vram_rdata;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic        vram_req;
  logic [7:0]  cpu_rdata;
  logic [13:0] ppu_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // VRAM model state
  logic [7:0]  mem [0:2047];
  int          wr_count = 0;
  logic [10:0] last_addr = 11'd0;
  logic [7:0]  last_data = 8'h00;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = 11'd0;
  logic [7:0]  pre_data = 8'h00;
  logic [1:0]  ce_cnt = 2'd0;

  ppudata_port dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .reg_sel    (reg_sel),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .cpu_wdata  (cpu_wdata),
    .inc32      (inc32),
    .mirror     (mirror),
    .vram_gnt   (vram_gnt),
    .vram_rdata (vram_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_req   (vram_req),
    .cpu_rdata  (cpu_rdata),
    .ppu_addr   (ppu_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Clock enable high one cycle in four.
  always @(negedge clk) begin
    ce_cnt = ce_cnt + 2'd1;
    clk_en = (ce_cnt == 2'd0);
  end

  // VRAM port 2 model: writes land on clk_en & we; bench preload port.
  always @(posedge clk) begin
    if (clk_en && vram_we) begin
      mem[vram_addr] <= vram_wdata;
      wr_count       <= wr_count + 1;
      last_addr      <= vram_addr;
      last_data      <= vram_wdata;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  assign vram_rdata = mem[vram_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [7:0] d);
    @(negedge clk);
    reg_sel = sel; cpu_wdata = d; reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  // Returns cpu_rdata as seen during the strobe cycle.
  task automatic reg_read(input logic [2:0] sel, output logic [7:0] d);
    @(negedge clk);
    reg_sel = sel; reg_rd = 1'b1;
    #1 d = cpu_rdata;
    @(negedge clk);
    reg_rd = 1'b0;
  endtask

  task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
    reg_write(3'd6, hi);
    reg_write(3'd6, lo);
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [10:0] exp;
  } map_vec_t;

  map_vec_t mv [7];

  initial begin
    int          n;
    int          base;
    int          we_seen;
    int          idle_seen;
    logic [7:0]  rd;

    // $2C05: A11=1, A10=1; $2405: A11=0, A10=1; $3005 mirrors $2005.
    mv[0] = '{2'd0, 8'h2C, 8'h05, 11'h405};
    mv[1] = '{2'd1, 8'h2C, 8'h05, 11'h405};
    mv[2] = '{2'd3, 8'h2C, 8'h05, 11'h405};
    mv[3] = '{2'd2, 8'h2C, 8'h05, 11'h005};
    mv[4] = '{2'd0, 8'h24, 8'h05, 11'h005};
    mv[5] = '{2'd1, 8'h24, 8'h05, 11'h405};
    mv[6] = '{2'd0, 8'h30, 8'h05, 11'h005};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {20'd0, vram_addr, vram_we, vram_wdata, vram_req, cpu_rdata, ppu_addr, busy}, 64'd0);
    rst = 1'b0;

    // 1: write $2108 with vertical mirroring
    mirror = 2'd1;
    set_addr(8'h21, 8'h08);
    check("t1_addr_latch", {50'd0, ppu_addr}, 64'h2108);
    reg_write(3'd7, 8'hAB);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_req", {63'd0, vram_req}, 64'd1);
    wait_idle("t1_idle_timeout", n);
    check("t1_latency_le4", {63'd0, (n <= 4)}, 64'd1);
    check("t1_wr_count", 64'(wr_count), 64'd1);
    check("t1_wr_addr", {53'd0, last_addr}, 64'h108);
    check("t1_wr_data", {56'd0, last_data}, 64'hAB);
    check("t1_ppu_addr", {50'd0, ppu_addr}, 64'h2109);
    check("t1_we_low", {63'd0, vram_we}, 64'd0);

    // 2: buffered reads from $2000, horizontal mirroring
    mirror = 2'd0;
    preload(11'h000, 8'h5A);
    preload(11'h001, 8'h3C);
    set_addr(8'h20, 8'h00);
    reg_read(3'd7, rd);
    check("t2_read1_stale", {56'd0, rd}, 64'h00);
    wait_idle("t2_idle1_timeout", n);
    check("t2_addr_2001", {50'd0, ppu_addr}, 64'h2001);
    reg_read(3'd7, rd);
    check("t2_read2", {56'd0, rd}, 64'h5A);
    wait_idle("t2_idle2_timeout", n);
    check("t2_addr_2002", {50'd0, ppu_addr}, 64'h2002);
    check("t2_buf_next", {56'd0, cpu_rdata}, 64'h3C);

    // 3: palette accesses and address wrap
    base = wr_count;
    inc32 = 1'b1;
    set_addr(8'h3F, 8'hE0);
    reg_write(3'd7, 8'h11);
    check("t3_pal_not_busy", {63'd0, busy}, 64'd0);
    check("t3_wrap32", {50'd0, ppu_addr}, 64'h0000);
    set_addr(8'h3F, 8'hE0);
    reg_read(3'd7, rd);
    check("t3_pal_read_stale", {56'd0, rd}, 64'h3C);
    check("t3_pal_buf_clear", {56'd0, cpu_rdata}, 64'h00);
    inc32 = 1'b0;
    set_addr(8'h3F, 8'hFF);
    reg_write(3'd7, 8'h22);
    check("t3_wrap1", {50'd0, ppu_addr}, 64'h0000);
    repeat (6) @(negedge clk);
    check("t3_no_vram_write", 64'(wr_count), 64'(base));

    // 4: mirroring modes
    for (int i = 0; i < 7; i++) begin
      mirror = mv[i].m;
      set_addr(mv[i].hi, mv[i].lo);
      reg_write(3'd7, 8'h40 + 8'(i));
      wait_idle("t4_idle_timeout", n);
      check($sformatf("t4_map_%0d_addr", i), {53'd0, last_addr}, {53'd0, mv[i].exp});
      check($sformatf("t4_map_%0d_data", i), {56'd0, last_data}, {56'd0, 8'h40 + 8'(i)});
    end

    // 5: grant withheld; collisions while busy
    mirror = 2'd0;
    set_addr(8'h23, 8'h00);
    base = wr_count;
    vram_gnt = 1'b0;
    reg_write(3'd7, 8'hC3);
    we_seen = 0;
    idle_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vram_we) we_seen++;
      if (!busy) idle_seen++;
    end
    check("t5_no_we_without_gnt", 64'(we_seen), 64'd0);
    check("t5_busy_held", 64'(idle_seen), 64'd0);
    reg_write(3'd7, 8'h99);
    reg_write(3'd6, 8'h05);
    check("t5_addr_write_while_busy", {50'd0, ppu_addr}, 64'h0500);
    check("t5_still_busy", {63'd0, busy}, 64'd1);
    vram_gnt = 1'b1;
    wait_idle("t5_idle_timeout", n);
    repeat (12) @(negedge clk);
    check("t5_single_commit", 64'(wr_count), 64'(base + 1));
    check("t5_commit_addr", {53'd0, last_addr}, 64'h300);
    check("t5_commit_data", {56'd0, last_data}, 64'hC3);
    check("t5_completion_overwrites", {50'd0, ppu_addr}, 64'h2301);
    reg_read(3'd2, rd);
    set_addr(8'h21, 8'h00);
    check("t5_status_clears_w", {50'd0, ppu_addr}, 64'h2100);

    // 6: reset during a pending write
    base = wr_count;
    vram_gnt = 1'b0;
    reg_write(3'd7, 8'hEE);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vram_gnt = 1'b1;
    #1;
    check("t6_reset_outputs", {20'd0, vram_addr, vram_we, vram_wdata, vram_req, cpu_rdata, ppu_addr, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_write", 64'(wr_count), 64'(base));
    check("t6_idle", {63'd0, busy}, 64'd0);
    reg_write(3'd6, 8'h22);
    check("t6_high_byte_first", {50'd0, ppu_addr}, 64'h2200);
    reg_write(3'd6, 8'h33);
    check("t6_low_byte", {50'd0, ppu_addr}, 64'h2233);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
